// File: rtl/dequantizer_pkg.sv
// dequantizer_pkg: shared widths, FSM state type and channel-to-table map for the dequantizer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dequantizer_pkg;

    localparam int QT_ENTRIES = 64;             // one entry per coefficient of an 8x8 block
    localparam int IN_W       = 12;             // signed input coefficient width
    localparam int QT_W       = 8;              // unsigned quantizer value width
    localparam int PROD_W     = IN_W + QT_W + 1; // signed x zero-extended unsigned product
    localparam int DQ_OUT_W   = 16;             // default output coefficient width

    // DQ state: IDLE (nothing held), PROC (row walk), DONE (block presented)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } dq_state_e;

    // Luma (channel 0) uses table 0; every chroma channel shares table 1.
    function automatic int unsigned ch_to_tbl(input int unsigned ch);
        return (ch == 32'd0) ? 32'd0 : 32'd1;
    endfunction

endpackage

// File: rtl/dequantizer_if.sv
// dequantizer_if: block input (pulse + slot-ready) and block output (valid/ready) bundle.
// Latency: n/a (wiring only).
// Backpressure: out_ready stalls the held output block; in_ready reports holding-slot space.
interface dequantizer_if
    import dequantizer_pkg::*;
#(
    parameter int OUT_W = DQ_OUT_W,
    parameter int CH_W  = 2
) ();

    logic [7:0][7:0][IN_W-1:0]  block_in;
    logic                       valid_in;
    logic [CH_W-1:0]            ch_in;
    logic                       in_ready;

    logic [7:0][7:0][OUT_W-1:0] block_out;
    logic [CH_W-1:0]            ch_out;
    logic                       out_valid;
    logic                       out_ready;

    // Producer of input blocks / consumer of output blocks
    modport master (
        output block_in, valid_in, ch_in, out_ready,
        input  in_ready, block_out, ch_out, out_valid
    );

    // The dequantizer itself
    modport slave (
        input  block_in, valid_in, ch_in, out_ready,
        output in_ready, block_out, ch_out, out_valid
    );

endinterface

// File: rtl/dequantizer_row.sv
// dequant_row: eight coefficient x quantizer multipliers for one block row, reduced to OUT_W.
// Latency: combinational.
// Backpressure: none; build option DEQUANT_SAT_EN saturates instead of wrapping.
module dequant_row
    import dequantizer_pkg::*;
#(
    parameter int OUT_W = DQ_OUT_W
) (
    input  logic [7:0][IN_W-1:0]  row_in,
    input  logic [7:0][QT_W-1:0]  qt_row,
    output logic [7:0][OUT_W-1:0] row_out
);

    logic [7:0][PROD_W-1:0] prod;

    // Signed coefficient times zero-extended quantizer; the low PROD_W bits are exact
    always_comb begin
        for (int c = 0; c < 8; c++) begin
            prod[c] = {{(PROD_W-IN_W){row_in[c][IN_W-1]}}, row_in[c]}
                    * {{(PROD_W-QT_W){1'b0}}, qt_row[c]};
        end
    end

    // Reduce each product to OUT_W: clamp when saturation is built in, otherwise keep low bits
    always_comb begin
        for (int c = 0; c < 8; c++) begin
`ifdef DEQUANT_SAT_EN
            if ((&prod[c][PROD_W-1:OUT_W-1]) || !(|prod[c][PROD_W-1:OUT_W-1])) begin
                row_out[c] = prod[c][OUT_W-1:0];
            end else if (prod[c][PROD_W-1]) begin
                row_out[c] = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                row_out[c] = {1'b0, {(OUT_W-1){1'b1}}};
            end
`else
            row_out[c] = OUT_W'(prod[c]);
`endif
        end
    end

endmodule

// File: rtl/dequantizer.sv
// dequantizer: row-serial 8x8 dequantization (coef x qt[channel table]), one row per cycle, in place.
// Latency: out_valid 9 cycles after valid_in from IDLE; peak one block per 9 cycles.
// Backpressure: output held until out_ready; one block buffered in a slot, further arrivals dropped (sticky overflow).
// Build option: DEQUANT_SAT_EN selects saturating rather than wrapping output reduction.
module dequantizer
    import dequantizer_pkg::*;
#(
    parameter int NUM_QT = 2,            // at least 2: channels >= 1 use table 1
    parameter int OUT_W  = DQ_OUT_W,     // IN_W <= OUT_W <= PROD_W
    parameter int CH     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dequantizer_if.slave              bus,
    input  logic                      qt_wr_en,
    input  logic [$clog2(NUM_QT)-1:0] qt_wr_sel,
    input  logic [5:0]                qt_wr_addr,
    input  logic [QT_W-1:0]           qt_wr_data,
    output logic                      overflow
);

    localparam int CH_W  = $clog2(CH + 1);
    localparam int TBL_W = $clog2(NUM_QT);

    dq_state_e                             state_q, state_d;
    logic [2:0]                            row_q, row_d;
    logic [7:0][7:0][OUT_W-1:0]            work_q, work_d;
    logic [CH_W-1:0]                       ch_q, ch_d;
    logic [7:0][7:0][IN_W-1:0]             slot_q, slot_d;
    logic [CH_W-1:0]                       slot_ch_q, slot_ch_d;
    logic                                  slot_full_q, slot_full_d;
    logic                                  overflow_q, overflow_d;
    logic [NUM_QT-1:0][QT_ENTRIES-1:0][QT_W-1:0] qt_q, qt_d;

    logic [TBL_W-1:0]                      tbl_idx;
    logic [7:0][IN_W-1:0]                  row_in;
    logic [7:0][QT_W-1:0]                  row_qt;
    logic [7:0][OUT_W-1:0]                 row_res;
    logic                                  drain;

    // Current row operands: unprocessed rows still hold the sign-extended input, so the low IN_W bits are the coefficient
    always_comb begin
        tbl_idx = TBL_W'(ch_to_tbl(32'(ch_q)));
        for (int c = 0; c < 8; c++) begin
            row_in[c] = work_q[row_q][c][IN_W-1:0];
            row_qt[c] = qt_q[tbl_idx][{row_q, 3'(c)}];
        end
    end

    dequant_row #(.OUT_W(OUT_W)) u_row (
        .row_in  (row_in),
        .qt_row  (row_qt),
        .row_out (row_res)
    );

    // Table write port: live tables, a write lands at the edge and is seen by the next row computed
    always_comb begin
        qt_d = qt_q;
        if (qt_wr_en) begin
            qt_d[qt_wr_sel][qt_wr_addr] = qt_wr_data;
        end
    end

    // Block FSM plus holding-slot bookkeeping
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        work_d      = work_q;
        ch_d        = ch_q;
        slot_d      = slot_q;
        slot_ch_d   = slot_ch_q;
        slot_full_d = slot_full_q;
        overflow_d  = overflow_q;
        drain       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    for (int r = 0; r < 8; r++) begin
                        for (int c = 0; c < 8; c++) begin
                            work_d[r][c] = OUT_W'($signed(bus.block_in[r][c]));
                        end
                    end
                    ch_d    = bus.ch_in;
                    row_d   = 3'd0;
                    state_d = PROC;
                end
            end
            PROC: begin
                work_d[row_q] = row_res;
                row_d         = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (slot_full_q) begin
                        drain = 1'b1;
                        for (int r = 0; r < 8; r++) begin
                            for (int c = 0; c < 8; c++) begin
                                work_d[r][c] = OUT_W'($signed(slot_q[r][c]));
                            end
                        end
                        ch_d        = slot_ch_q;
                        slot_full_d = 1'b0;
                        row_d       = 3'd0;
                        state_d     = PROC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Arrivals while busy go to the slot; a slot freed this same cycle takes the new block
        if (bus.valid_in && (state_q != IDLE)) begin
            if (!slot_full_q || drain) begin
                slot_d      = bus.block_in;
                slot_ch_d   = bus.ch_in;
                slot_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State registers; reset abandons any block in flight and restores unity tables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            work_q      <= '0;
            ch_q        <= '0;
            slot_q      <= '0;
            slot_ch_q   <= '0;
            slot_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            qt_q        <= {(NUM_QT*QT_ENTRIES){8'd1}};
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            work_q      <= work_d;
            ch_q        <= ch_d;
            slot_q      <= slot_d;
            slot_ch_q   <= slot_ch_d;
            slot_full_q <= slot_full_d;
            overflow_q  <= overflow_d;
            qt_q        <= qt_d;
        end
    end

    assign bus.block_out = work_q;
    assign bus.ch_out    = ch_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.in_ready  = !slot_full_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_dequantizer.sv
// tb_dequantizer: directed scoreboard bench for the dequantizer.
// Latency: checks 9-cycle block latency, slot hand-off timing and reset abandonment.
// Backpressure: exercises out_ready stalls, slot fill, overflow drop and same-cycle drain/refill.
`timescale 1ns/1ps
module tb_dequantizer;
    import dequantizer_pkg::*;

    localparam int OW = 16;
    localparam int CW = 2;

    typedef logic [7:0][7:0][IN_W-1:0] blk_in_t;
    typedef logic [7:0][7:0][OW-1:0]   blk_out_t;
    typedef struct {
        blk_out_t        blk;
        logic [CW-1:0]   ch;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            qt_wr_en;
    logic [0:0]      qt_wr_sel;
    logic [5:0]      qt_wr_addr;
    logic [7:0]      qt_wr_data;
    logic            overflow;

    int              errors = 0;
    int              checks = 0;
    int              qt_m [2][64];
    exp_t            sb [$];
    exp_t            mon_e;
    int              mon_r, mon_c;
    blk_in_t         b;
    exp_t            e;
    logic [OW-1:0]   e00;

    dequantizer_if #(.OUT_W(OW), .CH_W(CW)) bus ();

    dequantizer #(.NUM_QT(2), .OUT_W(OW), .CH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .qt_wr_en   (qt_wr_en),
        .qt_wr_sel  (qt_wr_sel),
        .qt_wr_addr (qt_wr_addr),
        .qt_wr_data (qt_wr_data),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: wrap or clamp to 16 bits
    function automatic logic [OW-1:0] dq(input int a, input int q);
        int p;
        p = a * q;
`ifdef DEQUANT_SAT_EN
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
`endif
        return OW'(p);
    endfunction

    function automatic exp_t make_exp(input blk_in_t bi, input int ch);
        exp_t x;
        int   t;
        t = (ch == 0) ? 0 : 1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                x.blk[r][c] = dq(int'($signed(bi[r][c])), qt_m[t][r*8+c]);
        x.ch = CW'(ch);
        return x;
    endfunction

    function automatic blk_in_t rand_blk();
        blk_in_t x;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                x[r][c] = 12'($urandom_range(0, 4095));
        return x;
    endfunction

    task automatic send(input blk_in_t bi, input int ch);
        bus.block_in = bi;
        bus.ch_in    = CW'(ch);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic qt_write(input int sel, input int addr, input int data);
        qt_wr_en   = 1'b1;
        qt_wr_sel  = 1'(sel);
        qt_wr_addr = 6'(addr);
        qt_wr_data = 8'(data);
        tick();
        qt_wr_en   = 1'b0;
        qt_m[sel][addr] = data;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n;
        n = 0;
        while (!bus.out_valid && n < max) begin
            tick();
            n++;
        end
        checks++;
        assert (bus.out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s: out_valid observed=%0b after %0d cycles, expected 1", tag, bus.out_valid, n);
        end
    endtask

    task automatic drain_all(input string tag, input int max);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: every accepted block must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_block: observed ch=%0d, expected no block", bus.ch_out);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                mon_r = 0;
                mon_c = 0;
                for (int r = 7; r >= 0; r--)
                    for (int c = 7; c >= 0; c--)
                        if (bus.block_out[r][c] !== mon_e.blk[r][c]) begin
                            mon_r = r;
                            mon_c = c;
                        end
                checks++;
                assert (bus.block_out === mon_e.blk) else begin
                    errors++;
                    $error("FAIL block_data: at [%0d][%0d] observed=%0d expected=%0d", mon_r, mon_c,
                           $signed(bus.block_out[mon_r][mon_c]), $signed(mon_e.blk[mon_r][mon_c]));
                end
                checks++;
                assert (bus.ch_out === mon_e.ch) else begin
                    errors++;
                    $error("FAIL block_ch: observed=%0d expected=%0d", bus.ch_out, mon_e.ch);
                end
            end
        end
    end

    initial begin
        bus.block_in  = '0;
        bus.valid_in  = 1'b0;
        bus.ch_in     = '0;
        bus.out_ready = 1'b0;
        qt_wr_en      = 1'b0;
        qt_wr_sel     = '0;
        qt_wr_addr    = '0;
        qt_wr_data    = '0;
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 64; a++)
                qt_m[t][a] = 1;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_ch_out", 32'(bus.ch_out), 32'd0);
        chk("rst_block00", 32'(bus.block_out[0][0]), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table 0 all 2, block of all 3 on channel 0 -> all 6, 9-cycle latency
        for (int a = 0; a < 64; a++) qt_write(0, a, 2);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 12'd3;
        sb.push_back(make_exp(b, 0));
        bus.out_ready = 1'b1;
        send(b, 0);
        repeat (7) tick();
        chk("lat_t8_not_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_t9_valid", 32'(bus.out_valid), 32'd1);
        chk("all3_elem77", 32'(bus.block_out[7][7]), 32'd6);
        tick();

        // Positive extreme through table 1 on channel 2
        qt_write(1, 0, 255);
        b = rand_blk();
        b[0][0] = 12'h7FF;
        sb.push_back(make_exp(b, 2));
        bus.out_ready = 1'b0;
        send(b, 2);
        wait_valid("pos_valid", 20);
`ifdef DEQUANT_SAT_EN
        e00 = 16'h7FFF;
`else
        e00 = 16'hF701;
`endif
        chk("pos_extreme", 32'(bus.block_out[0][0]), 32'(e00));
        bus.out_ready = 1'b1;
        tick();

        // Negative extreme
        b = rand_blk();
        b[0][0] = 12'h800;
        sb.push_back(make_exp(b, 2));
        bus.out_ready = 1'b0;
        send(b, 2);
        wait_valid("neg_valid", 20);
`ifdef DEQUANT_SAT_EN
        e00 = 16'h8000;
`else
        e00 = 16'h0800;
`endif
        chk("neg_extreme", 32'(bus.block_out[0][0]), 32'(e00));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Pulses at t and t+3 with out_ready low: second block parks in the slot
        b = rand_blk();
        sb.push_back(make_exp(b, 0));
        send(b, 0);
        tick();
        tick();
        b = rand_blk();
        sb.push_back(make_exp(b, 1));
        send(b, 1);
        chk("slot_full_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid("A_valid", 20);
        chk("A_no_overflow", 32'(overflow), 32'd0);
        repeat (3) tick();
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_ch", 32'(bus.ch_out), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("h1_in_ready", 32'(bus.in_ready), 32'd1);
        chk("h1_not_valid", 32'(bus.out_valid), 32'd0);
        repeat (7) tick();
        chk("h8_not_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("h9_valid", 32'(bus.out_valid), 32'd1);
        chk("h9_ch", 32'(bus.ch_out), 32'd1);
        chk("B_no_overflow", 32'(overflow), 32'd0);

        // Fill the slot, then a further pulse is dropped with sticky overflow
        b = rand_blk();
        sb.push_back(make_exp(b, 2));
        send(b, 2);
        chk("C_in_ready", 32'(bus.in_ready), 32'd0);
        chk("C_no_overflow", 32'(overflow), 32'd0);
        b = rand_blk();
        send(b, 3);
        chk("drop_overflow", 32'(overflow), 32'd1);
        tick();
        chk("overflow_sticky", 32'(overflow), 32'd1);

        // New pulse in the same cycle the slot drains: it takes the freed slot
        b = rand_blk();
        sb.push_back(make_exp(b, 3));
        bus.out_ready = 1'b1;
        send(b, 3);
        bus.out_ready = 1'b0;
        chk("refill_in_ready", 32'(bus.in_ready), 32'd0);
        drain_all("drain_slot_blocks", 100);
        repeat (12) tick();
        chk("no_phantom_valid", 32'(bus.out_valid), 32'd0);
        chk("overflow_still", 32'(overflow), 32'd1);

        // Reset during row 4 abandons the block and restores unity tables
        b = rand_blk();
        send(b, 2);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_ch_out", 32'(bus.ch_out), 32'd0);
        checks++;
        assert (bus.block_out === '0) else begin
            errors++;
            $error("FAIL mid_rst_block: observed block_out[0][0]=%0h, expected all zero", bus.block_out[0][0]);
        end
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 2; t++)
            for (int a = 0; a < 64; a++)
                qt_m[t][a] = 1;
        b = rand_blk();
        sb.push_back(make_exp(b, 0));
        bus.out_ready = 1'b1;
        send(b, 0);
        b = rand_blk();
        sb.push_back(make_exp(b, 1));
        send(b, 1);
        drain_all("drain_unity", 60);

        // Random tables with a zero entry; a mid-block write to row 7 is seen by that row
        for (int a = 0; a < 64; a++) qt_write(0, a, int'($urandom_range(0, 255)));
        for (int a = 0; a < 64; a++) qt_write(1, a, int'($urandom_range(0, 255)));
        qt_write(1, 5, 0);
        b = rand_blk();
        send(b, 3);
        qt_write(1, 59, 77);
        e = make_exp(b, 3);
        sb.push_back(e);
        wait_valid("live_table_valid", 20);
        chk("live_table_73", 32'(bus.block_out[7][3]), 32'(dq(int'($signed(b[7][3])), 77)));
        chk("qt_zero_05", 32'(bus.block_out[0][5]), 32'd0);
        b = rand_blk();
        sb.push_back(make_exp(b, 0));
        tick();
        send(b, 0);
        drain_all("drain_random", 60);

        repeat (3) tick();
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
